// File: rtl/updown_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate and terminal-count pulse.
// Optional sticky overflow flag enabled by defining UPDOWN_COUNTER_STICKY_EN.
module updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 2**WIDTH,
  parameter bit SATURATE  = 1'b0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Compares run at WIDTH+1 bits so MODULO = 2**WIDTH needs no special casing.
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] MAX_V   = MAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             at_top, at_bot, boundary, load_clamp;

  always_comb begin
    at_top     = ({1'b0, count_q} == MAX_W);
    at_bot     = (count_q == '0);
    load_clamp = ({1'b0, load_val} >= MOD_W);
    boundary   = 1'b0;
    count_d    = count_q;
    tc_d       = 1'b0;
    if (load) begin
      count_d = load_clamp ? MAX_V : load_val;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          boundary = 1'b1;
          count_d  = SATURATE ? MAX_V : '0;
        end else begin
          count_d  = count_q + 1'b1;
        end
      end else begin
        if (at_bot) begin
          boundary = 1'b1;
          count_d  = SATURATE ? '0 : MAX_V;
        end else begin
          count_d  = count_q - 1'b1;
        end
      end
      tc_d = boundary;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_V;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

`ifdef UPDOWN_COUNTER_STICKY_EN
  logic ovf_q, ovf_d;

  // A boundary on the same edge as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (boundary) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Directed + short random bench for updown_counter: three instances (mod 10 wrap,
// mod 10 saturate, mod 16 wrap) share stimulus and are checked against a scoreboard.
module tb_updown_counter;
  localparam int NDUT = 3;
  localparam int MODS [NDUT] = '{10, 10, 16};
  localparam int SATS [NDUT] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       reset, en, up, load, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] cnt_o [NDUT];
  logic       tc_o  [NDUT];
  logic       ovf_o [NDUT];

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .RESET_VAL(0)) u_wrap10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));
  updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1), .RESET_VAL(0)) u_sat10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));
  updown_counter #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0), .RESET_VAL(0)) u_wrap16 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .count(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

  typedef struct {
    int   id;
    int   cnt;
    logic tc;
    logic ovf;
  } exp_t;

  exp_t sb [$];
  int   m_cnt [NDUT];
  logic m_tc  [NDUT];
  logic m_ovf [NDUT];
  int   errors = 0;
  int   checks = 0;
`ifdef UPDOWN_COUNTER_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // Behavioural reference for one instance, advanced one clock edge.
  task automatic model(input int d, input logic r, input logic l, input logic e,
                       input logic u, input logic c, input int lv);
    bit hit;
    hit = 1'b0;
    if (r) begin
      m_cnt[d] = 0; m_tc[d] = 1'b0; m_ovf[d] = 1'b0;
      return;
    end
    if (l) begin
      m_cnt[d] = (lv > MODS[d] - 1) ? MODS[d] - 1 : lv;
    end else if (e && u) begin
      if (m_cnt[d] == MODS[d] - 1) begin
        hit = 1'b1;
        if (SATS[d] == 0) m_cnt[d] = 0;
      end else m_cnt[d] = m_cnt[d] + 1;
    end else if (e) begin
      if (m_cnt[d] == 0) begin
        hit = 1'b1;
        if (SATS[d] == 0) m_cnt[d] = MODS[d] - 1;
      end else m_cnt[d] = m_cnt[d] - 1;
    end
    m_tc[d] = hit;
    if (STICKY) begin
      if (hit) m_ovf[d] = 1'b1;
      else if (c) m_ovf[d] = 1'b0;
    end else m_ovf[d] = 1'b0;
  endtask

  task automatic step(input string tag, input logic r, input logic l, input logic e,
                      input logic u, input logic c, input logic [3:0] lv);
    exp_t x;
    reset = r; load = l; en = e; up = u; ovf_clr = c; load_val = lv;
    for (int d = 0; d < NDUT; d++) begin
      model(d, r, l, e, u, c, int'(lv));
      x.id = d; x.cnt = m_cnt[d]; x.tc = m_tc[d]; x.ovf = m_ovf[d];
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      assert (int'(cnt_o[x.id]) === x.cnt) else begin
        errors++;
        $error("FAIL %s dut%0d count got=%0d exp=%0d", tag, x.id, cnt_o[x.id], x.cnt);
      end
      checks++;
      assert (tc_o[x.id] === x.tc) else begin
        errors++;
        $error("FAIL %s dut%0d tc got=%b exp=%b", tag, x.id, tc_o[x.id], x.tc);
      end
      checks++;
      assert (ovf_o[x.id] === x.ovf) else begin
        errors++;
        $error("FAIL %s dut%0d ovf got=%b exp=%b", tag, x.id, ovf_o[x.id], x.ovf);
      end
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; ovf_clr = 1'b0; load_val = '0;
    for (int d = 0; d < NDUT; d++) begin
      m_cnt[d] = 0; m_tc[d] = 1'b0; m_ovf[d] = 1'b0;
    end
    // reset with en high, then 10 up steps (wraps mod 10)
    step("reset", 1, 0, 1, 1, 0, 4'd0);
    for (int i = 0; i < 10; i++) step("up10", 0, 0, 1, 1, 0, 4'd0);
    step("hold_ovf", 0, 0, 0, 1, 0, 4'd0);
    // down from 0
    step("rst2", 1, 0, 0, 1, 0, 4'd0);
    for (int i = 0; i < 3; i++) step("down0", 0, 0, 1, 0, 0, 4'd0);
    // load wins over en, clamp above modulus
    step("load7", 0, 1, 1, 1, 0, 4'd7);
    step("load12", 0, 1, 1, 1, 0, 4'd12);
    step("load15", 0, 1, 0, 0, 0, 4'd15);
    // direction toggle, then hold
    step("load5", 0, 1, 0, 1, 0, 4'd5);
    for (int i = 0; i < 4; i++) step("toggle", 0, 0, 1, (i % 2) == 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) step("en0", 0, 0, 0, 1, 0, 4'd0);
    // reset mid-count
    step("load8", 0, 1, 0, 1, 0, 4'd8);
    step("rst_mid", 1, 0, 1, 1, 0, 4'd0);
    // sticky flag: set, hold, set-wins-over-clear, clear alone
    step("ld9a", 0, 1, 0, 1, 0, 4'd9);
    step("wrap9", 0, 0, 1, 1, 0, 4'd0);
    step("ovf_hold", 0, 0, 0, 1, 0, 4'd0);
    step("ld9b", 0, 1, 0, 1, 0, 4'd9);
    step("set_clr", 0, 0, 1, 1, 1, 4'd0);
    step("clr", 0, 0, 0, 1, 1, 4'd0);
    step("clr2", 0, 0, 0, 1, 0, 4'd0);
    // mod 16 wrap 15 -> 0
    step("ld15", 0, 1, 0, 1, 0, 4'd15);
    step("wrap15", 0, 0, 1, 1, 0, 4'd0);
    step("clr3", 0, 0, 0, 1, 1, 4'd0);
    // short random mix
    for (int i = 0; i < 60; i++)
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
